// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin write arbiter into the TX FIFO with occupancy
// tracking, plus the pop/load/start/wait sequencer that feeds the transmitter.
module uart_tx_sched #(
  parameter int NUM_REQ    = 2,
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 4095
) (
  input  logic                 clk_tx_sched,
  input  logic                 rst_tx_sched,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 fifo_wr_en,
  output logic [7:0]           fifo_wr_data,
  output logic                 fifo_rd_en,
  output logic                 tx_start,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic [4:0]           fifo_count,
  output logic                 full,
  output logic                 empty,
  output logic                 timeout_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [4:0]    DEPTH_C  = 5'(DEPTH);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PW:0]   NREQ_C   = (PW + 1)'(NUM_REQ);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [4:0]    count_q, count_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          rd_en_q, rd_en_d;
  logic          start_q, start_d;
  logic          err_q, err_d;
  logic          push;
  logic          pop;

  assign fifo_count  = count_q;
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == 5'd0);
  assign fifo_rd_en  = rd_en_q;
  assign tx_start    = start_q;
  assign timeout_err = err_q;
  assign push        = |(req_valid & req_ready);
  assign fifo_wr_en  = push;
  assign pop         = rd_en_q;

  // Grant the first valid requester at or after the pointer; blocked when full.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;
    req_ready    = '0;
    fifo_wr_data = '0;
    rr_ptr_d     = rr_ptr_q;
    found        = 1'b0;
    sum          = '0;
    idx          = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PW + 1)'(k);
      if (sum >= NREQ_C) begin
        sum = sum - NREQ_C;
      end
      idx = sum[PW-1:0];
      if (!full && !found && req_valid[idx]) begin
        found          = 1'b1;
        req_ready[idx] = 1'b1;
        fifo_wr_data   = req_data[{idx, 3'b000} +: 8];
        rr_ptr_d       = (idx == PTR_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // Occupancy follows push minus pop, clamped to 0..DEPTH.
  always_comb begin
    count_d = count_q;
    if (push && !pop && count_q != DEPTH_C) begin
      count_d = count_q + 5'd1;
    end else if (!push && pop && count_q != 5'd0) begin
      count_d = count_q - 5'd1;
    end
  end

  // Sequencer next state; strobes are computed one cycle early so they
  // come out of flops aligned with the POP and START states.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    rd_en_d = 1'b0;
    start_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable && !empty && !tx_busy) begin
          state_d = S_POP;
          rd_en_d = 1'b1;
        end
      end
      S_POP: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_START;
        start_d = 1'b1;
      end
      S_START: begin
        state_d = S_WAIT;
        wd_d    = '0;
      end
      S_WAIT: begin
        if (tx_done) begin
          state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          gap_d   = '0;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset wins on any edge it is high.
  always_ff @(posedge clk_tx_sched) begin
    if (rst_tx_sched) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      count_q  <= '0;
      wd_q     <= '0;
      gap_q    <= '0;
      rd_en_q  <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      wd_q     <= wd_d;
      gap_q    <= gap_d;
      rd_en_q  <= rd_en_d;
      start_q  <= start_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side controller for the UART. It arbitrates byte writes from `NUM_REQ` requesters into the 16-entry TX FIFO using round-robin, and keeps its own occupancy count. It also sequences the FIFO-to-transmitter handoff (pop, load, start, wait for done) with a programmable inter-frame gap and a watchdog timeout. It sits between the system-side byte producers and the `fifo_tx` plus transmitter pair.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..4.
- `DEPTH`, 16: TX FIFO depth in bytes; the count saturates logic at this value.
- `GAP_CYCLES`, 0: idle cycles inserted after `tx_done` before the next pop.
- `TIMEOUT`, 4095: maximum cycles in WAIT before the error flag is raised.
- `clk_tx_sched` in 1: single clock; all logic is on the rising edge.
- `rst_tx_sched` in 1: reset, synchronous and active-high.
- `enable` in 1: when 0, no new pop starts; writes still accepted.
- `req_valid` in NUM_REQ: per-requester byte valid.
- `req_data` in 8*NUM_REQ: requester i occupies bits [8i+7:8i].
- `req_ready` out NUM_REQ: one-hot grant, combinational.
- `fifo_wr_en` out 1: push strobe to the FIFO.
- `fifo_wr_data` out 8: granted byte.
- `fifo_rd_en` out 1: pop strobe to the FIFO (its `next_frame`).
- `tx_start` out 1: one-cycle start pulse to the transmitter.
- `tx_busy` in 1: transmitter is shifting.
- `tx_done` in 1: one-cycle end-of-frame pulse from the transmitter.
- `fifo_count` out 5: bytes held, 0..DEPTH.
- `full` out 1: `fifo_count==DEPTH`.
- `empty` out 1: `fifo_count==0`.
- `timeout_err` out 1: sticky; cleared only by reset.

## Operation
**Write arbitration (combinational grant, registered pointer)**
- When `full`==0, grant the first `i` with `req_valid[i]`=1, searching from `rr_ptr` upward modulo NUM_REQ. `req_ready` is one-hot at that `i`; otherwise all zeros.
- A transfer is `req_valid[i]` & `req_ready[i]`. On a transfer:
  - `fifo_wr_en`=1 and `fifo_wr_data`=`req_data[i]` in the same cycle.
  - `rr_ptr` <= (i+1) mod NUM_REQ.
- With no transfer, `rr_ptr` holds.
- With `full`=1, `req_ready`=0 and `fifo_wr_en`=0. A pop in the same cycle does not unblock the write.

**Occupancy**
- `fifo_count` next value = count + push − pop.
- Simultaneous push and pop leaves the count unchanged.
- The count never exceeds DEPTH and never goes below 0.

**Read FSM (Moore outputs)**
- IDLE: if `enable` & !`empty` & !`tx_busy`, go to POP.
- POP: `fifo_rd_en`=1 for one cycle; go to LOAD.
- LOAD: one cycle for the FIFO's registered `data_out` to settle; go to START.
- START: `tx_start`=1 for one cycle; clear the watchdog; go to WAIT.
- WAIT: on `tx_done`, go to GAP, or to IDLE if GAP_CYCLES=0.
  - The watchdog increments each cycle.
  - When it reaches TIMEOUT, set `timeout_err`=1 and go to IDLE. The byte is lost.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- Dropping `enable` mid-sequence completes the current frame. It only blocks the IDLE→POP transition.
- A `tx_done` outside WAIT is ignored.

**Reset**
- Takes effect on the edge where `rst_tx_sched`=1, regardless of state.
- Resulting values:
  - state=IDLE, `rr_ptr`=0, `fifo_count`=0, watchdog=0.
  - `timeout_err`=0, `fifo_rd_en`=0, `tx_start`=0.
  - `empty`=1, `full`=0.
- The FIFO and transmitter must be reset on the same edge.
- Reset mid-frame discards the frame; no `tx_start` is issued after reset until a new push.

## Timing
- From a push accepted in cycle N, with the FSM idle and `tx_busy`=0:
  - `fifo_count`=1 at N+1.
  - `fifo_rd_en`=1 at N+2.
  - `tx_start`=1 at N+4.
  - WAIT from N+5.
- Back-to-back frames with GAP_CYCLES=0: with `tx_done` in cycle M, the state is IDLE at M+1, `fifo_rd_en` at M+2 and `tx_start` at M+4.
- GAP_CYCLES=G adds exactly G cycles.
- `fifo_count` decrements the cycle after POP.
- Maximum push rate is one byte per cycle.
- Maximum frame issue rate is one per (transmit time + 4 + G) cycles.

## Test plan
1. Reset, then req0 pushes 0xA5 at cycle 10 → `fifo_wr_en`@10, `fifo_rd_en`@12, `tx_start`@14. Drive `tx_done`@30 → IDLE@31 and `empty`=1.
2. NUM_REQ=2, both valid continuously for 6 cycles → grants alternate 0,1,0,1,0,1; `fifo_count`=6.
3. 16 pushes with `enable`=0 → `full`=1 and `req_ready`=0 on the 17th cycle. Raise `enable` → after the first POP, `full`=0 and the next push is accepted.
4. Push and pop in the same cycle with count=5 → count stays 5.
5. TIMEOUT=20, `tx_done` never asserted → `timeout_err`=1 exactly 20 cycles after WAIT entry, FSM back in IDLE, flag stays high until reset.
6. Assert `rst_tx_sched` during WAIT with count=3 → next cycle count=0, IDLE, all outputs at reset values, no `tx_start` afterward.
